// File: rtl/bmp_cmd_queue_if.sv
// Processor-side register bus for the BMP/font command queue.
interface bmp_cmd_queue_if;
  logic        sel;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (output sel, we, addr, wdata, input rdata);
  modport slave  (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/bmp_cmd_queue.sv
// Command FIFO + dispatcher feeding the BMP/font placer; optional BMP_AUTO_ADVANCE_EN
// steps XLOC by FONT_W after every accepted font push.
//   state   | meaning
//   S_IDLE  | waiting for a queued entry; pops the head into the output registers
//   S_ISSUE | add_img/add_fnt pulse cycle
//   S_WAIT  | holding indx/xloc/yloc until place_done
module bmp_cmd_queue #(
  parameter logic [15:0] BASE_ADDR = 16'hC008,
  parameter int          XW        = 10,
  parameter int          YW        = 9,
  parameter int          IW        = 6,
  parameter int          DEPTH     = 8,
  parameter int          FONT_W    = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bmp_cmd_queue_if.slave       bus,
  output logic                 add_img,
  output logic                 add_fnt,
  output logic [IW-1:0]        indx,
  output logic [XW-1:0]        xloc,
  output logic [YW-1:0]        yloc,
  input  logic                 place_done,
  output logic                 irq_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic          kind;
    logic [IW-1:0] idx;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  logic [XW-1:0] xreg_q, xreg_d;
  logic [YW-1:0] yreg_q, yreg_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  state_t        state_q, state_d;
  logic          add_img_q, add_img_d;
  logic          add_fnt_q, add_fnt_d;
  logic [IW-1:0] indx_q, indx_d;
  logic [XW-1:0] xloc_q, xloc_d;
  logic [YW-1:0] yloc_q, yloc_d;
  logic          irq_q, irq_d;

  logic   wr_x, wr_y, wr_cmd, wr_stat, rd_stat;
  logic   fifo_full, fifo_empty, pop, push_ok;
  entry_t head;
  logic [15:0] status;
  logic   unused_wdata;

`ifndef BMP_AUTO_ADVANCE_EN
  localparam int unused_font_w = FONT_W;
`endif

  assign wr_x    = bus.sel && bus.we && (bus.addr == BASE_ADDR);
  assign wr_y    = bus.sel && bus.we && (bus.addr == BASE_ADDR + 16'd1);
  assign wr_cmd  = bus.sel && bus.we && (bus.addr == BASE_ADDR + 16'd2);
  assign wr_stat = bus.sel && bus.we && (bus.addr == BASE_ADDR + 16'd3);
  assign rd_stat = bus.sel && (bus.addr == BASE_ADDR + 16'd3);
  assign unused_wdata = ^bus.wdata;

  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = wr_cmd && (!fifo_full || pop);

  always_comb begin
    status           = '0;
    status[15]       = ovf_q;
    status[14]       = fifo_full;
    status[13]       = fifo_empty;
    status[12]       = (state_q != S_IDLE);
    status[CW-1:0]   = count_q;
  end

  assign bus.rdata = rd_stat ? status : 16'h0000;

  always_comb begin
    xreg_d   = xreg_q;
    yreg_d   = yreg_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_x) xreg_d = bus.wdata[XW-1:0];
    if (wr_y) yreg_d = bus.wdata[YW-1:0];
    if (push_ok) begin
      mem_d[wr_ptr_q].kind = bus.wdata[0];
      mem_d[wr_ptr_q].idx  = bus.wdata[IW:1];
      mem_d[wr_ptr_q].x    = xreg_q;
      mem_d[wr_ptr_q].y    = yreg_q;
      wr_ptr_d             = wr_ptr_q + PW'(1);
`ifdef BMP_AUTO_ADVANCE_EN
      if (!bus.wdata[0]) xreg_d = xreg_q + XW'(FONT_W);
`endif
    end
    if (wr_cmd && !push_ok)              ovf_d = 1'b1;
    else if (wr_stat && bus.wdata[15])   ovf_d = 1'b0;
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    add_img_d = 1'b0;
    add_fnt_d = 1'b0;
    indx_d    = indx_q;
    xloc_d    = xloc_q;
    yloc_d    = yloc_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          add_img_d = head.kind;
          add_fnt_d = !head.kind;
          indx_d    = head.idx;
          xloc_d    = head.x;
          yloc_d    = head.y;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (place_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    irq_d = fifo_empty && (state_q == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xreg_q    <= '0;
      yreg_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= S_IDLE;
      add_img_q <= 1'b0;
      add_fnt_q <= 1'b0;
      indx_q    <= '0;
      xloc_q    <= '0;
      yloc_q    <= '0;
      irq_q     <= 1'b1;
    end else begin
      xreg_q    <= xreg_d;
      yreg_q    <= yreg_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      add_img_q <= add_img_d;
      add_fnt_q <= add_fnt_d;
      indx_q    <= indx_d;
      xloc_q    <= xloc_d;
      yloc_q    <= yloc_d;
      irq_q     <= irq_d;
    end
  end

  assign add_img   = add_img_q;
  assign add_fnt   = add_fnt_q;
  assign indx      = indx_q;
  assign xloc      = xloc_q;
  assign yloc      = yloc_q;
  assign irq_empty = irq_q;

endmodule

// File: doc/bmp_cmd_queue.md
Name: bmp_cmd_queue

Overview:
Memory-mapped command front-end for the BMP/font placement engine. The processor writes X/Y location registers and a command word. Each command is captured into a FIFO as a complete draw request, so software can issue bursts without polling. A dispatcher FSM pops one entry at a time and hands it to the placer with a pulse/done handshake. A status register exposes queue state and a sticky overflow flag.

Parameters:
BASE_ADDR, 16'hC008, base of the 4-word register window (BASE+0 XLOC, +1 YLOC, +2 CMD, +3 STATUS).
XW, 10, x coordinate width.
YW, 9, y coordinate width.
IW, 6, image/font index width.
DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
FONT_W, 13, x advance in pixels per font glyph (used only by the optional feature).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
sel  in  1  peripheral select from the address decoder.
we  in  1  bus write strobe.
addr  in  16  bus address.
wdata  in  16  bus write data.
rdata  out  16  bus read data; combinational, valid when sel and addr equals BASE+3, else 0.
add_img  out  1  one-cycle pulse: place image.
add_fnt  out  1  one-cycle pulse: place glyph.
indx  out  IW  image/font index, valid with the pulse.
xloc  out  XW  x location, valid with the pulse.
yloc  out  YW  y location, valid with the pulse.
place_done  in  1  one-cycle pulse from the placer when the current draw is complete.
irq_empty  out  1  registered; high while the FIFO is empty and the FSM is IDLE.

Behaviour:
- Reset values: all outputs 0 except irq_empty, which is 1. XLOC=0, YLOC=0, FIFO empty, ovf=0, FSM in IDLE.
- A write occurs when sel and we are high and addr matches. BASE+0 loads XLOC<=wdata[XW-1:0]. BASE+1 loads YLOC<=wdata[YW-1:0].
- BASE+2 pushes the entry {kind=wdata[0], idx=wdata[IW:1], XLOC, YLOC} into the FIFO. kind 1 means image, kind 0 means font.
- A push reads the XLOC/YLOC register values as they stand before that same cycle's write.
- BASE+3 write with wdata[15]=1 clears ovf. All other bits are ignored.
- STATUS read value: [15] ovf, [14] full, [13] empty, [12] busy (FSM not IDLE), [log2(DEPTH):0] count. All other bits are 0.
- Full: a push while full is dropped, sets ovf (sticky), and leaves the FIFO unchanged.
- If a push and a pop occur in the same cycle while full, the push is accepted and count is unchanged.
- Push and pop in the same cycle with 0 < count < DEPTH leaves count unchanged.
- Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head into the output registers and go to ISSUE.
  - ISSUE: assert add_img or add_fnt for exactly one cycle, holding indx, xloc and yloc. Go to WAIT.
  - WAIT: hold indx, xloc and yloc until place_done=1, then go to IDLE. A place_done outside WAIT is ignored.
- Latency: a CMD write in cycle N with the FIFO empty and FSM IDLE gives the pulse in cycle N+2. The earliest next pulse is 2 cycles after place_done.
- Back-to-back commands therefore cost 3 cycles plus the placer time.
- Reset mid-operation flushes the FIFO and returns to IDLE. No pulse is emitted in the cycle reset deasserts.
- irq_empty is registered: (count==0 and FSM IDLE), delayed one cycle.

Optional Feature:
BMP_AUTO_ADVANCE_EN
- Defined: each accepted font push (kind 0) then sets XLOC <= XLOC + FONT_W, truncated to XW bits (wraps).
  - Image pushes do not advance XLOC.
  - A dropped push does not advance XLOC.
  - An explicit XLOC write in the same cycle as a push is impossible (single bus). A later XLOC write overrides the advanced value.
- Undefined: XLOC changes only on writes to BASE+0.

Test Plan:
- Reset, then read BASE+3 -> rdata=16'h2000 (empty); irq_empty=1; all pulses 0.
- Write XLOC=100, YLOC=50, CMD=16'h0003 (image, idx 1) -> 2 cycles later add_img=1 for 1 cycle with indx=1, xloc=100, yloc=50. busy=1 until place_done is pulsed.
- Hold place_done low. Push DEPTH+2 commands -> the first is popped, the FIFO fills, STATUS reads ovf=1, full=1, count=DEPTH. Write BASE+3 with 16'h8000 -> ovf=0.
- Push 3 fonts idx 22, 36, 31 with XLOC=256, then pulse place_done each time -> add_fnt pulses appear in order with the same indices. xloc=256,256,256 without the feature; 256,269,282 with BMP_AUTO_ADVANCE_EN.
- Wrap: XLOC=1020 with FONT_W=13 and the feature on, push a font -> the next font's xloc=9.
- Assert rst_n low while in WAIT with 3 entries queued -> after release, count=0, no pulses, irq_empty=1 one cycle later.
